regfile_dbg_access: RTL and testbench

Debug-side initiator for the CPU register file. It lets an external debug host read and write any GPR through a valid/ready request/response interface, and it shares the regfile write port and read port 2 with the core. Core writeback has priority. A bounded wait counter stalls the core so debug writes cannot be starved. It sits between the debug transport and the regfile/writeback mux in the top level.

---
 rtl/regfile_dbg_access.sv | 146 ++++++++++++++
 tb/tb_regfile_dbg_access.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_access.sv
// regfile_dbg_access: debug-host initiator for the GPR file.
// Debug reads and writes are arbitrated against core writeback, and
// regfile write port / read port 2 are shared with the core.
// Core writeback has priority, but only for a bounded number of cycles.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   dbg_req_*           request channel (valid/ready, write, addr, wdata)
//   dbg_rsp_*           response channel (valid/ready, rdata, err)
//   core_we/waddr/wdata core writeback request
//   core_stall          core must hold its pipeline and writeback
//   rf_we/waddr/wdata   regfile write port
//   rf_rsel/raddr/rdata regfile read port 2 (this block owns it when rsel=1)
//
// Optional macro REGFILE_DBG_X0_ERR_EN: debug writes to x0 respond err=1.
module regfile_dbg_access #(
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_write,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [DATA_W-1:0] dbg_rsp_rdata,
    output logic              dbg_rsp_err,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_rsel,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);

    // Counter must be able to hold MAX_WAIT; keep at least one bit.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

`ifdef REGFILE_DBG_X0_ERR_EN
    localparam logic X0_ERR = 1'b1;
`else
    localparam logic X0_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic addr_zero;
    logic wait_done;
    logic dbg_rd;
    logic wr_pend;
    logic dbg_wr;

    assign addr_zero = (cap_addr == '0);
    assign wait_done = (wait_cnt == WAIT_MAX);

    // Read cycle: owns read port 2 and freezes the core for one cycle.
    assign dbg_rd  = (state == PEND) && !cap_write;
    // A real (non-x0) debug write is waiting for the write port.
    assign wr_pend = (state == PEND) && cap_write && !addr_zero;
    // Debug write issues when the core is idle or its patience ran out.
    assign dbg_wr  = wr_pend && (wait_done || !core_we);

    assign dbg_req_ready = (state == IDLE);
    assign dbg_rsp_valid = (state == RESP);

    // Stall depends only on registered state, never on core_we.
    assign core_stall = dbg_rd || (wr_pend && wait_done);
    assign rf_rsel    = dbg_rd;
    assign rf_raddr   = cap_addr;

    assign rf_we    = dbg_wr || (core_we && !core_stall);
    assign rf_waddr = dbg_wr ? cap_addr  : core_waddr;
    assign rf_wdata = dbg_wr ? cap_wdata : core_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            cap_write     <= 1'b0;
            cap_addr      <= '0;
            cap_wdata     <= '0;
            dbg_rsp_rdata <= '0;
            dbg_rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dbg_req_valid) begin
                        cap_write <= dbg_req_write;
                        cap_addr  <= dbg_req_addr;
                        cap_wdata <= dbg_req_wdata;
                        wait_cnt  <= '0;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (!cap_write) begin
                        dbg_rsp_rdata <= addr_zero ? '0 : rf_rdata;
                        dbg_rsp_err   <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= RESP;
                    end else if (addr_zero) begin
                        dbg_rsp_rdata <= '0;
                        dbg_rsp_err   <= X0_ERR;
                        wait_cnt      <= '0;
                        state         <= RESP;
                    end else if (dbg_wr) begin
                        dbg_rsp_rdata <= '0;
                        dbg_rsp_err   <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (dbg_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_access.sv
// tb_regfile_dbg_access: randomized self-checking bench.
// A behavioural GPR array predicts every debug read and final contents.
module tb_regfile_dbg_access;

    localparam int MW = 4;
    localparam int DW = 32;
    localparam int AW = 5;

`ifdef REGFILE_DBG_X0_ERR_EN
    localparam logic X0_ERR = 1'b1;
`else
    localparam logic X0_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dbg_req_valid = 1'b0;
    logic          dbg_req_ready;
    logic          dbg_req_write = 1'b0;
    logic [AW-1:0] dbg_req_addr = '0;
    logic [DW-1:0] dbg_req_wdata = '0;
    logic          dbg_rsp_valid;
    logic          dbg_rsp_ready = 1'b0;
    logic [DW-1:0] dbg_rsp_rdata;
    logic          dbg_rsp_err;
    logic          core_we = 1'b0;
    logic [AW-1:0] core_waddr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_rsel;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;

    int vectors = 0;
    int miscompares = 0;

    // Physical regfile seen by the DUT; x0 returns junk so the
    // DUT has to force zero itself.
    logic [DW-1:0] rf [32];
    logic          clear = 1'b1;
    // Reference contents predicted from the arbitration rules.
    logic [DW-1:0] ref_rf [32];

    always #5 clk = ~clk;

    assign rf_rdata = (rf_raddr == '0) ? 32'hBAD0_BAD0 : rf[rf_raddr];

    always @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    regfile_dbg_access #(.MAX_WAIT(MW), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
        .core_we(core_we), .core_waddr(core_waddr),
        .core_wdata(core_wdata), .core_stall(core_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rsel(rf_rsel), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 core idle, 1 core writes every cycle, 2 random.
    task automatic set_core(input int mode);
        core_we    = (mode == 1) ? 1'b1 :
                     (mode == 0) ? 1'b0 : 1'($urandom % 2);
        core_waddr = AW'($urandom_range(1, 31));
        core_wdata = $urandom;
    endtask

    // A core write lands only when the core is not being stalled.
    task automatic core_commit(input bit stalled);
        if (core_we && !stalled) ref_rf[core_waddr] = core_wdata;
    endtask

    task automatic do_txn(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int mode);
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        int            n;
        bit            done;
        int            hold;
        dbg_req_valid = 1'b1;
        dbg_req_write = wr;
        dbg_req_addr  = a;
        dbg_req_wdata = d;
        dbg_rsp_ready = 1'b0;
        set_core(mode);
        #2;
        if ({dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel} !== 4'b1000) begin
            $display("FAIL idle_flags got=%b want=1000",
                     {dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel});
            miscompares++;
        end
        vectors++;
        if (rf_we !== core_we ||
            (core_we && {rf_waddr, rf_wdata} !== {core_waddr, core_wdata})) begin
            $display("FAIL idle_pass we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                     rf_we, rf_waddr, rf_wdata, core_we, core_waddr, core_wdata);
            miscompares++;
        end
        vectors++;
        core_commit(1'b0);
        cyc();
        // Junk on the request channel must be ignored while busy.
        dbg_req_valid = 1'($urandom % 2);
        dbg_req_write = 1'($urandom % 2);
        dbg_req_addr  = AW'($urandom);
        dbg_req_wdata = $urandom;
        exp_rd  = '0;
        exp_err = 1'b0;
        if (!wr) begin
            set_core(mode);
            #2;
            exp_rd = (a == '0) ? '0 : ref_rf[a];
            if ({dbg_req_ready, core_stall, rf_rsel, rf_we} !== 4'b0110 ||
                rf_raddr !== a) begin
                $display("FAIL read_cycle flags=%b raddr=%0d want 0110 raddr=%0d",
                         {dbg_req_ready, core_stall, rf_rsel, rf_we}, rf_raddr, a);
                miscompares++;
            end
            vectors++;
            cyc();
        end else if (a == '0) begin
            set_core(mode);
            #2;
            exp_err = X0_ERR;
            if ({dbg_req_ready, core_stall, rf_rsel} !== 3'b000 ||
                rf_we !== core_we ||
                (rf_we && rf_waddr == '0)) begin
                $display("FAIL x0_write flags=%b we=%b a=%0d want 000 we=%b",
                         {dbg_req_ready, core_stall, rf_rsel}, rf_we, rf_waddr, core_we);
                miscompares++;
            end
            vectors++;
            core_commit(1'b0);
            cyc();
        end else begin
            n = 0;
            done = 0;
            while (!done) begin
                set_core(mode);
                #2;
                if (n < MW && core_we) begin
                    if (core_stall !== 1'b0 || rf_we !== 1'b1 ||
                        {rf_waddr, rf_wdata} !== {core_waddr, core_wdata}) begin
                        $display("FAIL wr_yield n=%0d st=%b we=%b a=%0d d=%h want a=%0d d=%h",
                                 n, core_stall, rf_we, rf_waddr, rf_wdata,
                                 core_waddr, core_wdata);
                        miscompares++;
                    end
                    vectors++;
                    core_commit(1'b0);
                    n++;
                end else begin
                    if (core_stall !== 1'(n == MW) || rf_we !== 1'b1 ||
                        {rf_waddr, rf_wdata} !== {a, d}) begin
                        $display("FAIL wr_issue n=%0d st=%b we=%b a=%0d d=%h want st=%b a=%0d d=%h",
                                 n, core_stall, rf_we, rf_waddr, rf_wdata,
                                 1'(n == MW), a, d);
                        miscompares++;
                    end
                    vectors++;
                    ref_rf[a] = d;
                    done = 1;
                end
                if ({dbg_req_ready, dbg_rsp_valid, rf_rsel} !== 3'b000) begin
                    $display("FAIL wr_pend_flags got=%b want=000",
                             {dbg_req_ready, dbg_rsp_valid, rf_rsel});
                    miscompares++;
                end
                vectors++;
                cyc();
            end
        end
        hold = $urandom_range(0, 3);
        for (int i = 0; i <= hold; i++) begin
            dbg_rsp_ready = (i == hold);
            dbg_req_valid = 1'b1;
            dbg_req_write = 1'($urandom % 2);
            dbg_req_addr  = AW'($urandom);
            set_core(mode);
            #2;
            if ({dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel} !== 4'b0100 ||
                dbg_rsp_rdata !== exp_rd || dbg_rsp_err !== exp_err) begin
                $display("FAIL resp addr=%0d flags=%b rd=%h err=%b want 0100 rd=%h err=%b",
                         a, {dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel},
                         dbg_rsp_rdata, dbg_rsp_err, exp_rd, exp_err);
                miscompares++;
            end
            vectors++;
            core_commit(1'b0);
            cyc();
        end
        dbg_req_valid = 1'b0;
        dbg_rsp_ready = 1'b0;
        core_we       = 1'b0;
        #2;
        if ({dbg_req_ready, dbg_rsp_valid} !== 2'b10) begin
            $display("FAIL back_idle got=%b want=10", {dbg_req_ready, dbg_rsp_valid});
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b1;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        cyc();
        cyc();
        #2;
        if ({dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel, rf_we} !== 5'b10000 ||
            dbg_rsp_rdata !== '0 || dbg_rsp_err !== 1'b0) begin
            $display("FAIL reset flags=%b rd=%h err=%b want 10000 rd=0 err=0",
                     {dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel, rf_we},
                     dbg_rsp_rdata, dbg_rsp_err);
            miscompares++;
        end
        vectors++;
        clear = 1'b0;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 5'd5, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 5'd5, '0, 2);
    endtask

    task automatic test_starve();
        do_txn(1'b1, 5'd7, 32'h0000_1234, 1);
        do_txn(1'b0, 5'd7, '0, 1);
    endtask

    task automatic test_x0();
        do_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 2);
        do_txn(1'b0, 5'd0, '0, 2);
    endtask

    task automatic test_reset_pend();
        logic [DW-1:0] pre;
        pre = ref_rf[9];
        do_txn(1'b0, 5'd9, '0, 0);
        dbg_req_valid = 1'b1;
        dbg_req_write = 1'b1;
        dbg_req_addr  = 5'd9;
        dbg_req_wdata = ~pre;
        set_core(1);
        core_commit(1'b0);
        cyc();
        dbg_req_valid = 1'b0;
        rst_n = 1'b0;
        set_core(1);
        core_commit(1'b0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_core(1);
            #2;
            if ({dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel} !== 4'b1000 ||
                dbg_rsp_rdata !== '0 || rf_we !== 1'b1) begin
                $display("FAIL reset_pend i=%0d flags=%b rd=%h we=%b want 1000 rd=0 we=1",
                         i, {dbg_req_ready, dbg_rsp_valid, core_stall, rf_rsel},
                         dbg_rsp_rdata, rf_we);
                miscompares++;
            end
            vectors++;
            core_commit(1'b0);
            cyc();
        end
        core_we = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom % 2), AW'($urandom_range(0, 31)), $urandom,
                   int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 32; a++) begin
            do_txn(1'b0, AW'(a), '0, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_starve();
        test_x0();
        test_reset_pend();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
